// File: rtl/sa_acc_drain_if.sv
// Drain-engine port bundle: drain command, bottom-PE accumulator input,
// PE column controls, status pulses and the valid/ready result stream.
interface sa_acc_drain_if #(
  parameter int ACC_BWIDTH = 32
);
  logic                         DRAIN_START;
  logic signed [ACC_BWIDTH-1:0] ACC_in;
  logic                         FLUSH_out;
  logic                         STALL_out;
  logic                         BUSY;
  logic                         DONE;
  logic signed [ACC_BWIDTH-1:0] RES_DATA;
  logic                         RES_VALID;
  logic                         RES_LAST;
  logic                         RES_READY;

  // drain engine side
  modport slave (
    input  DRAIN_START, ACC_in, RES_READY,
    output FLUSH_out, STALL_out, BUSY, DONE, RES_DATA, RES_VALID, RES_LAST
  );

  // array controller / PE column / result consumer side
  modport master (
    output DRAIN_START, ACC_in, RES_READY,
    input  FLUSH_out, STALL_out, BUSY, DONE, RES_DATA, RES_VALID, RES_LAST
  );
endinterface

// File: rtl/sa_acc_drain.sv
// Column drain engine for the bottom edge of the systolic array.
// Flushes one PE column ROWS times (bottom row first), captures the bottom
// PE's accumulator on each shift into a small FIFO, and streams the results
// out on a valid/ready port. The column is stalled while the FIFO is full.
// Optional build macro SA_DRAIN_RELU_EN: negative captures are pushed as 0.
module sa_acc_drain #(
  parameter int ACC_BWIDTH = 32,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic           CLK,
  input logic           RST,
  sa_acc_drain_if.slave io
);
  localparam int            CW       = $clog2(ROWS + 1);
  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, TAIL} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [PW:0]           wr_ptr_q, rd_ptr_q;
  logic [ACC_BWIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last_q;

  logic [PW-1:0]         wr_idx, rd_idx;
  logic                  fifo_full, fifo_empty;
  logic                  capture, cap_last, pop, head_last;
  logic [ACC_BWIDTH-1:0] push_data;

  assign wr_idx     = wr_ptr_q[PW-1:0];
  assign rd_idx     = rd_ptr_q[PW-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);

  // A full FIFO blocks the push even if a pop frees a slot this cycle; the
  // column is stalled by the same term, so PE shift and capture stay locked.
  assign capture   = (state_q == DRAIN) && !fifo_full;
  assign cap_last  = capture && (cnt_q == LAST_IDX);
  assign pop       = !fifo_empty && io.RES_READY;
  assign head_last = mem_last_q[rd_idx];

`ifdef SA_DRAIN_RELU_EN
  assign push_data = io.ACC_in[ACC_BWIDTH-1] ? '0 : io.ACC_in;
`else
  assign push_data = io.ACC_in;
`endif

  // Next-state logic: start, count captures, finish on the last result out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.DRAIN_START) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (capture) cnt_d = cnt_q + 1'b1;
        if (cap_last) state_d = TAIL;
      end
      TAIL: begin
        if (pop && head_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Result FIFO storage and pointers (extra MSB distinguishes full/empty)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_last_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_data_q[i] <= '0;
    end else begin
      if (capture) begin
        mem_data_q[wr_idx] <= push_data;
        mem_last_q[wr_idx] <= cap_last;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign io.FLUSH_out = (state_q == DRAIN);
  assign io.STALL_out = (state_q == DRAIN) && fifo_full;
  assign io.BUSY      = (state_q != IDLE);
  assign io.DONE      = done_q;
  assign io.RES_VALID = !fifo_empty;
  assign io.RES_DATA  = fifo_empty ? '0 : mem_data_q[rd_idx];
  assign io.RES_LAST  = !fifo_empty && head_last;
endmodule

// File: tb/tb_sa_acc_drain.sv
// Bench for sa_acc_drain: a 4-row column with a 2-entry FIFO (back-pressure)
// and a 1-row column, each fed by a simple shifting PE column model.
`timescale 1ns/1ps
module tb_sa_acc_drain;
  localparam int W       = 32;
  localparam int ROWS_A  = 4;
  localparam int DEPTH_A = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sa_acc_drain_if #(.ACC_BWIDTH(W)) ifa ();
  sa_acc_drain_if #(.ACC_BWIDTH(W)) ifb ();

  sa_acc_drain #(.ACC_BWIDTH(W), .ROWS(ROWS_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
    .CLK(CLK), .RST(RST), .io(ifa)
  );
  sa_acc_drain #(.ACC_BWIDTH(W), .ROWS(1), .FIFO_DEPTH(4)) dut_b (
    .CLK(CLK), .RST(RST), .io(ifb)
  );

  // PE column models: index 0 is the bottom PE, top input tied to 0
  logic signed [W-1:0] col_a [ROWS_A];
  logic signed [W-1:0] col_b;
  assign ifa.ACC_in = col_a[0];
  assign ifb.ACC_in = col_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [ROWS_A-1:0][W-1:0] col_t;
  typedef struct {
    col_t sums;
    col_t expv;
    int   mode;   // 0: ready=1, 1: random ready, 2: ready low for 10 cycles
    bit   spur;   // extra DRAIN_START pulses while busy
  } vec_t;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic signed [W-1:0] ref_relu(input logic signed [W-1:0] v);
`ifdef SA_DRAIN_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic col_t col4(input int a, input int b, input int c, input int d);
    col_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // One clock: PEs shift at the edge when flushed and not stalled
  task automatic tick();
    logic sha, shb;
    sha = ifa.FLUSH_out && !ifa.STALL_out;
    shb = ifb.FLUSH_out && !ifb.STALL_out;
    @(posedge CLK);
    #1;
    if (sha) begin
      for (int i = 0; i < ROWS_A - 1; i++) col_a[i] = col_a[i+1];
      col_a[ROWS_A-1] = '0;
    end
    if (shb) col_b = '0;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " flush"}, ifa.FLUSH_out, 0);
    chk({tag, " stall"}, ifa.STALL_out, 0);
    chk({tag, " busy"},  ifa.BUSY, 0);
    chk({tag, " done"},  ifa.DONE, 0);
    chk({tag, " valid"}, ifa.RES_VALID, 0);
    chk({tag, " data"},  longint'(ifa.RES_DATA), 0);
    chk({tag, " last"},  ifa.RES_LAST, 0);
  endtask

  // Full drain on the 4-row column, checked cycle by cycle against a model
  // that only counts captures and acceptances.
  task automatic run_drain(input vec_t v, input string tag);
    int  caps, acc, flush_cyc, stall_cyc, cyc;
    bit  started, finished, prev_hold, xfer, capd, exp_flush;
    logic signed [W-1:0] prev_data;
    logic prev_last;
    for (int i = 0; i < ROWS_A; i++) col_a[i] = v.sums[i];
    caps = 0; acc = 0; flush_cyc = 0; stall_cyc = 0;
    started = 0; finished = 0; prev_hold = 0;
    prev_data = '0; prev_last = 0;
    for (cyc = 0; cyc < 200 && !finished; cyc++) begin
      ifa.DRAIN_START = (cyc == 0) || (v.spur && started && $urandom_range(0, 2) == 0);
      case (v.mode)
        0:       ifa.RES_READY = 1'b1;
        1:       ifa.RES_READY = 1'($urandom_range(0, 1));
        default: ifa.RES_READY = (cyc >= 10);
      endcase
      exp_flush = started && caps < ROWS_A;
      chk($sformatf("%s c%0d flush", tag, cyc), ifa.FLUSH_out, exp_flush);
      chk($sformatf("%s c%0d stall", tag, cyc), ifa.STALL_out,
          exp_flush && (caps - acc) == DEPTH_A);
      chk($sformatf("%s c%0d valid", tag, cyc), ifa.RES_VALID, caps > acc);
      chk($sformatf("%s c%0d busy", tag, cyc), ifa.BUSY, started);
      chk($sformatf("%s c%0d done", tag, cyc), ifa.DONE, 0);
      if (caps > acc) begin
        chk($sformatf("%s c%0d data", tag, cyc), longint'(ifa.RES_DATA),
            longint'(signed'(v.expv[acc])));
        chk($sformatf("%s c%0d last", tag, cyc), ifa.RES_LAST, acc == ROWS_A - 1);
      end
      if (prev_hold) begin
        chk($sformatf("%s c%0d hold data", tag, cyc), longint'(ifa.RES_DATA), longint'(prev_data));
        chk($sformatf("%s c%0d hold last", tag, cyc), ifa.RES_LAST, prev_last);
      end
      xfer      = ifa.RES_VALID && ifa.RES_READY;
      capd      = ifa.FLUSH_out && !ifa.STALL_out;
      prev_hold = ifa.RES_VALID && !ifa.RES_READY;
      prev_data = ifa.RES_DATA;
      prev_last = ifa.RES_LAST;
      if (ifa.FLUSH_out) flush_cyc++;
      if (ifa.STALL_out) stall_cyc++;
      tick();
      started = 1;
      if (capd) caps++;
      if (xfer) acc++;
      if (acc == ROWS_A) begin
        chk({tag, " done pulse"}, ifa.DONE, 1);
        chk({tag, " busy with done"}, ifa.BUSY, 0);
        chk({tag, " valid with done"}, ifa.RES_VALID, 0);
        finished = 1;
      end
    end
    if (!finished) chk({tag, " timeout"}, 0, 1);
    ifa.DRAIN_START = 1'b0;
    ifa.RES_READY   = 1'b1;
    tick();
    chk({tag, " single done"}, ifa.DONE, 0);
    chk({tag, " captures"}, caps, ROWS_A);
    if (v.mode == 0) chk({tag, " flush cycles"}, flush_cyc, ROWS_A);
    if (v.mode == 2) chk({tag, " stalled"}, stall_cyc > 0, 1);
  endtask

  vec_t vecs[4];
  vec_t rv;

  initial begin
    bit   started_b, hold_b, xfer_b, capd_b, fin_b;
    int   caps_b, acc_b, flush_b;
    logic signed [W-1:0] held_b;

    vecs[0] = '{col4(10, -3, 7, 32'h7FFFFFFF), col4(10, -3, 7, 32'h7FFFFFFF), 0, 1'b0};
    vecs[1] = '{col4(111, 222, 333, 444),      col4(111, 222, 333, 444),      2, 1'b0};
    vecs[2] = '{col4(21, 22, 23, 24),          col4(21, 22, 23, 24),          1, 1'b1};
`ifdef SA_DRAIN_RELU_EN
    vecs[3] = '{col4(10, -3, 7, -1),           col4(10, 0, 7, 0),             0, 1'b0};
`else
    vecs[3] = '{col4(10, -3, 7, -1),           col4(10, -3, 7, -1),           0, 1'b0};
`endif

    for (int i = 0; i < ROWS_A; i++) col_a[i] = '0;
    col_b = '0;
    ifa.DRAIN_START = 1'b0; ifa.RES_READY = 1'b1;
    ifb.DRAIN_START = 1'b0; ifb.RES_READY = 1'b1;

    // reset state
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_idle_a("reset");
    chk("reset b busy", ifb.BUSY, 0);
    chk("reset b valid", ifb.RES_VALID, 0);
    RST = 1'b0;

    // table-driven drains
    for (int k = 0; k < 4; k++) run_drain(vecs[k], $sformatf("vec%0d", k));

    // reset two cycles into a back-pressured drain
    for (int i = 0; i < ROWS_A; i++) col_a[i] = 50 + i;
    ifa.RES_READY   = 1'b0;
    ifa.DRAIN_START = 1'b1;
    tick();
    ifa.DRAIN_START = 1'b0;
    tick();
    tick();
    chk("pre-rst valid", ifa.RES_VALID, 1);
    chk("pre-rst stall", ifa.STALL_out, 1);
    RST = 1'b1;
    #1;
    chk_idle_a("mid-rst");
    #2;
    RST = 1'b0;
    tick();
    chk_idle_a("post-rst");
    run_drain('{col4(-8, 9, -10, 11),
                col4(ref_relu(-8), 9, ref_relu(-10), 11), 0, 1'b0}, "after-rst");

    // randomized drains against the count-based model
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < ROWS_A; i++) begin
        rv.sums[i] = $urandom;
        rv.expv[i] = ref_relu(signed'(rv.sums[i]));
      end
      rv.mode = $urandom_range(0, 2);
      rv.spur = 1'b1;
      run_drain(rv, $sformatf("rnd%0d", r));
    end

    // single-row column with RES_READY toggling every cycle
    col_b = -5;
    started_b = 0; hold_b = 0; fin_b = 0;
    caps_b = 0; acc_b = 0; flush_b = 0; held_b = '0;
    for (int cyc = 0; cyc < 20 && !fin_b; cyc++) begin
      ifb.DRAIN_START = (cyc == 0);
      ifb.RES_READY   = cyc[0];
      chk($sformatf("b c%0d flush", cyc), ifb.FLUSH_out, started_b && caps_b < 1);
      chk($sformatf("b c%0d valid", cyc), ifb.RES_VALID, caps_b > acc_b);
      if (caps_b > acc_b) begin
        chk($sformatf("b c%0d data", cyc), longint'(ifb.RES_DATA), longint'(ref_relu(-5)));
        chk($sformatf("b c%0d last", cyc), ifb.RES_LAST, 1);
      end
      if (hold_b) chk($sformatf("b c%0d hold", cyc), longint'(ifb.RES_DATA), longint'(held_b));
      xfer_b = ifb.RES_VALID && ifb.RES_READY;
      capd_b = ifb.FLUSH_out && !ifb.STALL_out;
      hold_b = ifb.RES_VALID && !ifb.RES_READY;
      held_b = ifb.RES_DATA;
      if (ifb.FLUSH_out) flush_b++;
      tick();
      started_b = 1;
      if (capd_b) caps_b++;
      if (xfer_b) begin
        acc_b++;
        chk("b done pulse", ifb.DONE, 1);
        chk("b busy with done", ifb.BUSY, 0);
        fin_b = 1;
      end
    end
    if (!fin_b) chk("b timeout", 0, 1);
    ifb.DRAIN_START = 1'b0;
    tick();
    chk("b single done", ifb.DONE, 0);
    chk("b flush cycles", flush_b, 1);
    chk("b held a cycle", caps_b == 1 && acc_b == 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
